// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the single-port RAM to the dcache or the icache, with the dcache first; one grant at a time, each held until its access completes.
// Define MEM_ARBITER_STARVE_GUARD_EN to force an icache grant after STARVE_LIMIT consecutive dcache grants taken while a fetch waits.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [ADDR_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [ADDR_W-1:0] dstore,
    output logic              dwait,
    output logic [ADDR_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [ADDR_W-1:0] ramstore,
    input  logic [ADDR_W-1:0] ramload,
    input  logic [1:0]        ramstate
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] IGNT   = 2'd1;
    localparam logic [1:0] DGNT   = 2'd2;
    localparam logic [1:0] ACCESS = 2'b10;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] iload_q, iload_d, dload_q, dload_d;
    logic              d_req, i_on, d_on, i_done, d_done, i_first;

    // A granted requester that drops its request loses the RAM enables in that same cycle.
    assign d_req  = dREN | dWEN;
    assign i_on   = state_q == IGNT && iREN;
    assign d_on   = state_q == DGNT && d_req;
    assign i_done = i_on && ramstate == ACCESS;
    assign d_done = d_on && ramstate == ACCESS;

`ifdef MEM_ARBITER_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_q, starve_d;

    assign i_first = iREN && starve_q == CW'(STARVE_LIMIT);

    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE && (!iREN || state_d == IGNT))
            starve_d = '0;
        else if (state_q == IDLE && state_d == DGNT && starve_q != CW'(STARVE_LIMIT))
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            starve_q <= '0;
        else
            starve_q <= starve_d;
    end
`else
    logic unused_starve_limit;
    assign unused_starve_limit = STARVE_LIMIT != 0;
    assign i_first             = 1'b0;
`endif

    // Completion always passes through IDLE so the still-held request is not re-issued.
    always_comb begin
        state_d = IDLE;
        if (state_q == IDLE)
            state_d = (d_req && !i_first) ? DGNT : iREN ? IGNT : IDLE;
        else if (state_q == IGNT)
            state_d = (!iREN || i_done) ? IDLE : IGNT;
        else if (state_q == DGNT)
            state_d = (!d_req || d_done) ? IDLE : DGNT;
        iload_d = i_done ? ramload : iload_q;
        dload_d = (d_done && !dWEN) ? ramload : dload_q;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            iload_q <= '0;
            dload_q <= '0;
        end else begin
            state_q <= state_d;
            iload_q <= iload_d;
            dload_q <= dload_d;
        end
    end

    assign ramREN   = i_on || (d_on && !dWEN);
    assign ramWEN   = d_on && dWEN;
    assign ramaddr  = state_q == IGNT ? iaddr : state_q == DGNT ? daddr : '0;
    assign ramstore = ramWEN ? dstore : '0;
    assign iwait    = !i_done;
    assign dwait    = !d_done;
    assign iload    = iload_d;
    assign dload    = dload_d;
endmodule
